// File: rtl/bus_region_decoder.sv
// 68000 bus-cycle region decoder: registered one-hot selects, DTACK/BERR generation,
// per-region wait states with optional device handshake, and savestate override decodes.
module bus_region_decoder #(
  parameter int unsigned NUM_REGIONS = 12,
  parameter int unsigned WS_W        = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cpu_ce,
  input  logic                           cpu_as_n,
  input  logic [1:0]                     cpu_ds_n,
  input  logic [23:0]                    cpu_word_addr,
  input  logic                           ss_override,
  input  logic [16*NUM_REGIONS-1:0]      cfg_region,
  input  logic [WS_W*NUM_REGIONS-1:0]    cfg_wait,
  input  logic [NUM_REGIONS-1:0]         cfg_use_ack,
  input  logic [NUM_REGIONS-1:0]         dev_ack,
  output logic [NUM_REGIONS-1:0]         sel_n,
  output logic                           ss_reset_n,
  output logic                           ss_vec_n,
  output logic                           ss_save_n,
  output logic                           dtack_n,
  output logic                           berr_n,
  output logic [$clog2(NUM_REGIONS)-1:0] hit_index,
  output logic                           multi_hit
);

  localparam int unsigned HW = $clog2(NUM_REGIONS);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_HOLD,
    S_UNMAPPED,
    S_BERR
  } state_t;

  state_t                 r_state;
  logic [23:0]            r_addr;
  logic [WS_W-1:0]        r_wait;
  logic [TW-1:0]          r_to;
  logic [HW-1:0]          r_hit;
  logic [NUM_REGIONS-1:0] r_sel_n;
  logic                   r_ss_reset_n;
  logic                   r_ss_vec_n;
  logic                   r_ss_save_n;
  logic                   r_dtack_n;
  logic                   r_berr_n;
  logic                   r_multi;

  logic [NUM_REGIONS-1:0] w_match;
  logic [HW-1:0]          w_hit;
  logic [WS_W-1:0]        w_ws;
  logic                   w_any;
  logic                   w_multi;
  logic                   w_ss_rst;
  logic                   w_ss_vec;
  logic                   w_ss_sav;
  logic                   w_ss_any;
  logic                   w_ack_ok;
  logic                   w_to_last;

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      w_match[i] = ((r_addr[23:16] & cfg_region[16*i +: 8]) == cfg_region[16*i+8 +: 8]);
    end
  end

  // Walk from the top index down so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = '0;
    w_ws  = '0;
    for (int unsigned i = NUM_REGIONS; i > 0; i--) begin
      if (w_match[i-1]) begin
        w_hit = HW'(i - 1);
        w_ws  = cfg_wait[WS_W*(i-1) +: WS_W];
      end
    end
  end

  always_comb begin
    w_any     = |w_match;
    w_multi   = |(w_match & (w_match - NUM_REGIONS'(1)));
    w_ss_rst  = ss_override && (r_addr[23:4] == '0);
    w_ss_vec  = ss_override && ((r_addr == 24'h00007c) || (r_addr == 24'h00007e));
    w_ss_sav  = ss_override && (r_addr[23:8] == 16'hff00);
    w_ss_any  = w_ss_rst || w_ss_vec || w_ss_sav;
    w_ack_ok  = !cfg_use_ack[r_hit] || dev_ack[r_hit];
    w_to_last = (r_to == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wait       <= '0;
      r_to         <= '0;
      r_hit        <= '0;
      r_sel_n      <= '1;
      r_ss_reset_n <= 1'b1;
      r_ss_vec_n   <= 1'b1;
      r_ss_save_n  <= 1'b1;
      r_dtack_n    <= 1'b1;
      r_berr_n     <= 1'b1;
      r_multi      <= 1'b0;
    end else if ((r_state != S_IDLE) && cpu_as_n) begin
      // Strobe release ends the cycle from any active state, including normal HOLD/BERR exit.
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_to         <= '0;
      r_sel_n      <= '1;
      r_ss_reset_n <= 1'b1;
      r_ss_vec_n   <= 1'b1;
      r_ss_save_n  <= 1'b1;
      r_dtack_n    <= 1'b1;
      r_berr_n     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!cpu_as_n && (cpu_ds_n != 2'b11)) begin
            r_addr  <= cpu_word_addr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_to <= '0;
          if (w_multi) begin
            r_multi <= 1'b1;
          end
          if (w_ss_any) begin
            r_ss_reset_n <= !w_ss_rst;
            r_ss_vec_n   <= !w_ss_vec;
            r_ss_save_n  <= !w_ss_sav;
            r_wait       <= '0;
            r_dtack_n    <= 1'b0;
            r_state      <= S_ACK;
          end else if (w_any) begin
            r_sel_n <= ~(NUM_REGIONS'(1) << w_hit);
            r_hit   <= w_hit;
            r_wait  <= w_ws;
            r_state <= S_WAIT;
          end else begin
            r_hit   <= '0;
            r_state <= S_UNMAPPED;
          end
        end
        S_WAIT: begin
          if ((r_wait == '0) && w_ack_ok) begin
            r_dtack_n <= 1'b0;
            r_state   <= S_ACK;
          end else if (cpu_ce) begin
            if (r_wait != '0) begin
              r_wait <= r_wait - WS_W'(1);
            end
            if (w_to_last) begin
              r_berr_n <= 1'b0;
              r_sel_n  <= '1;
              r_state  <= S_BERR;
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
        end
        S_ACK: begin
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_state <= S_HOLD;
        end
        S_UNMAPPED: begin
          if (cpu_ce) begin
            if (w_to_last) begin
              r_berr_n <= 1'b0;
              r_sel_n  <= '1;
              r_state  <= S_BERR;
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
        end
        S_BERR: begin
          r_state <= S_BERR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sel_n      = r_sel_n;
  assign ss_reset_n = r_ss_reset_n;
  assign ss_vec_n   = r_ss_vec_n;
  assign ss_save_n  = r_ss_save_n;
  assign dtack_n    = r_dtack_n;
  assign berr_n     = r_berr_n;
  assign hit_index  = r_hit;
  assign multi_hit  = r_multi;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed plus randomized bench for bus_region_decoder against a transaction-level model.
module tb_bus_region_decoder;

  localparam int NR   = 12;
  localparam int WS   = 4;
  localparam int TOUT = 64;

  logic              clk;
  logic              reset_n;
  logic              cpu_ce;
  logic              cpu_as_n;
  logic [1:0]        cpu_ds_n;
  logic [23:0]       cpu_word_addr;
  logic              ss_override;
  logic [16*NR-1:0]  cfg_region;
  logic [WS*NR-1:0]  cfg_wait;
  logic [NR-1:0]     cfg_use_ack;
  logic [NR-1:0]     dev_ack;
  logic [NR-1:0]     sel_n;
  logic              ss_reset_n;
  logic              ss_vec_n;
  logic              ss_save_n;
  logic              dtack_n;
  logic              berr_n;
  logic [3:0]        hit_index;
  logic              multi_hit;

  bus_region_decoder #(
    .NUM_REGIONS (NR),
    .WS_W        (WS),
    .TIMEOUT     (TOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_ce        (cpu_ce),
    .cpu_as_n      (cpu_as_n),
    .cpu_ds_n      (cpu_ds_n),
    .cpu_word_addr (cpu_word_addr),
    .ss_override   (ss_override),
    .cfg_region    (cfg_region),
    .cfg_wait      (cfg_wait),
    .cfg_use_ack   (cfg_use_ack),
    .dev_ack       (dev_ack),
    .sel_n         (sel_n),
    .ss_reset_n    (ss_reset_n),
    .ss_vec_n      (ss_vec_n),
    .ss_save_n     (ss_save_n),
    .dtack_n       (dtack_n),
    .berr_n        (berr_n),
    .hit_index     (hit_index),
    .multi_hit     (multi_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit exp_multi = 1'b0;

  logic [7:0] m_match [NR];
  logic [7:0] m_mask  [NR];
  logic [3:0] m_wait  [NR];
  bit         m_use   [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},   32'(sel_n), 32'({NR{1'b1}}));
    chk({tag, "_dtack"}, 32'(dtack_n), 32'd1);
    chk({tag, "_berr"},  32'(berr_n), 32'd1);
    chk({tag, "_ss"},    32'({ss_reset_n, ss_vec_n, ss_save_n}), 32'h7);
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NR; i++) begin
      cfg_region[16*i +: 16] = {m_match[i], m_mask[i]};
      cfg_wait[WS*i +: WS]   = m_wait[i];
      cfg_use_ack[i]         = m_use[i];
    end
  endtask

  // Reference: which window claims an address, how many claim it, and which savestate
  // decode (1 reset vector page, 2 vector words, 3 save page) the override selects.
  task automatic ref_decode(input logic [23:0] a, input bit ovr,
                            output int hit, output int nmatch, output int ss);
    hit = -1;
    nmatch = 0;
    ss = 0;
    for (int i = NR - 1; i >= 0; i--) begin
      if ((a[23:16] & m_mask[i]) == m_match[i]) begin
        hit = i;
        nmatch++;
      end
    end
    if (ovr) begin
      if (a < 24'h000010) ss = 1;
      else if (a == 24'h00007c || a == 24'h00007e) ss = 2;
      else if (a >= 24'hff0000 && a <= 24'hff00ff) ss = 3;
    end
  endtask

  // One bus cycle. ack_after: ticks before the selected device reports ready (-1 = never).
  // abort_kind 1 drops the strobe, 2 pulses reset, before waiting iteration abort_at.
  task automatic do_cycle(input logic [23:0] addr, input bit ovr, input int period,
                          input int ack_after, input int abort_kind, input int abort_at);
    int hit, nm, ss, ticks, k, limit;
    bit done;
    logic [NR-1:0] es;
    logic exp_dt, exp_be;
    ref_decode(addr, ovr, hit, nm, ss);
    ss_override   = ovr;
    cpu_word_addr = addr;
    cpu_as_n      = 1'b0;
    case ($urandom_range(0, 2))
      0: cpu_ds_n = 2'b00;
      1: cpu_ds_n = 2'b01;
      default: cpu_ds_n = 2'b10;
    endcase
    cpu_ce  = 1'b0;
    dev_ack = NR'($urandom);
    @(posedge clk); @(negedge clk);
    chk("strobe_detect_sel", 32'(sel_n), 32'({NR{1'b1}}));
    @(posedge clk); @(negedge clk);
    if (nm >= 2) exp_multi = 1'b1;
    es = '1;
    if (ss == 0 && hit >= 0) es[hit] = 1'b0;
    chk("decode_sel", 32'(sel_n), 32'(es));
    chk("decode_multi", 32'(multi_hit), 32'(exp_multi));
    chk("decode_ss", 32'({ss_reset_n, ss_vec_n, ss_save_n}),
        32'({ss != 1, ss != 2, ss != 3}));
    if (ss == 0 && hit >= 0) chk("decode_hit_index", 32'(hit_index), 32'(hit));
    cpu_word_addr = 24'($urandom);
    exp_dt = 1'b1;
    exp_be = 1'b1;
    done   = 1'b0;
    ticks  = 0;
    if (ss != 0) begin
      @(posedge clk); @(negedge clk);
      exp_dt = 1'b0;
      done   = 1'b1;
      chk("ss_dtack", 32'(dtack_n), 32'd0);
    end
    limit = TOUT * period + 40;
    k = 0;
    while (k < limit && !done && !(abort_kind != 0 && k == abort_at)) begin
      cpu_ce = ((cyc % period) == 0);
      cyc++;
      dev_ack = NR'($urandom);
      if (hit >= 0) dev_ack[hit] = (ack_after >= 0 && ticks >= ack_after);
      if (ss == 0 && hit >= 0 && ticks >= int'(m_wait[hit]) && (!m_use[hit] || dev_ack[hit])) begin
        exp_dt = 1'b0;
        done   = 1'b1;
      end else if (cpu_ce) begin
        ticks++;
        if (ticks == TOUT) begin
          exp_be = 1'b0;
          es     = '1;
          done   = 1'b1;
        end
      end
      @(posedge clk); @(negedge clk);
      chk("wait_dtack", 32'(dtack_n), 32'(exp_dt));
      chk("wait_berr",  32'(berr_n),  32'(exp_be));
      chk("wait_sel",   32'(sel_n),   32'(es));
      k++;
    end
    cpu_ce = 1'b0;
    if (abort_kind == 1 && !done) begin
      cpu_as_n = 1'b1;
      cpu_ds_n = 2'b11;
      @(posedge clk); @(negedge clk);
      chk_idle("strobe_loss");
      @(posedge clk); @(negedge clk);
    end else if (abort_kind == 2 && !done) begin
      #2 reset_n = 1'b0;
      #1;
      chk_idle("mid_reset");
      chk("mid_reset_hit", 32'(hit_index), 32'd0);
      chk("mid_reset_multi", 32'(multi_hit), 32'd0);
      exp_multi = 1'b0;
      @(posedge clk); @(negedge clk);
      cpu_as_n = 1'b1;
      cpu_ds_n = 2'b11;
      reset_n  = 1'b1;
      @(posedge clk); @(negedge clk);
    end else begin
      chk("cycle_bound", 32'(done), 32'd1);
      @(posedge clk); @(negedge clk);
      chk("hold_dtack", 32'(dtack_n), 32'(exp_dt));
      chk("hold_berr",  32'(berr_n),  32'(exp_be));
      chk("hold_sel",   32'(sel_n),   32'(es));
      cpu_as_n = 1'b1;
      cpu_ds_n = 2'b11;
      @(posedge clk); @(negedge clk);
      chk_idle("release");
      chk("release_multi", 32'(multi_hit), 32'(exp_multi));
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ub;
    logic [7:0] ub_list [13];
    int ri;
    ub_list = '{8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
                8'h60, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hFF};

    m_match = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h80, 8'h20, 8'h55, 8'h60, 8'hF0, 8'h01, 8'h50, 8'hE0};
    m_mask  = '{8'hF8, 8'hFF, 8'hF0, 8'hFF, 8'hC0, 8'hFF, 8'h00, 8'hE0, 8'hF0, 8'h00, 8'hF8, 8'hF8};
    m_wait  = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd1, 4'd4};
    m_use   = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    apply_cfg();

    reset_n       = 1'b0;
    cpu_ce        = 1'b0;
    cpu_as_n      = 1'b1;
    cpu_ds_n      = 2'b11;
    cpu_word_addr = '0;
    ss_override   = 1'b0;
    dev_ack       = '0;
    @(negedge clk); @(negedge clk);
    chk_idle("reset");
    chk("reset_hit", 32'(hit_index), 32'd0);
    chk("reset_multi", 32'(multi_hit), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Address strobe without data strobes must not start a cycle.
    cpu_as_n = 1'b0;
    cpu_word_addr = 24'h040000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("no_ds_sel", 32'(sel_n), 32'({NR{1'b1}}));
    end
    cpu_as_n = 1'b1;
    @(negedge clk);

    do_cycle(24'h040000, 1'b0, 4, 0, 0, 0);
    m_wait[1] = 4'd3;
    apply_cfg();
    do_cycle(24'h100000, 1'b0, 4, 0, 0, 0);
    do_cycle(24'h200000, 1'b0, 1, 0, 0, 0);
    do_cycle(24'h100000, 1'b0, 2, 0, 0, 0);
    do_cycle(24'hC00000, 1'b0, 1, 0, 0, 0);
    do_cycle(24'h300000, 1'b0, 1, 10, 0, 0);
    do_cycle(24'h300000, 1'b0, 1, -1, 0, 0);
    do_cycle(24'h000004, 1'b1, 1, 0, 0, 0);
    do_cycle(24'h00007e, 1'b1, 1, 0, 0, 0);
    do_cycle(24'h00007c, 1'b1, 1, 0, 0, 0);
    do_cycle(24'hff0012, 1'b1, 1, 0, 0, 0);
    do_cycle(24'h000004, 1'b0, 1, 0, 0, 0);
    do_cycle(24'h00007e, 1'b0, 1, 0, 0, 0);
    do_cycle(24'hff0012, 1'b0, 1, 0, 0, 0);
    do_cycle(24'h600000, 1'b0, 1, 0, 0, 0);
    do_cycle(24'h800000, 1'b0, 2, 0, 1, 3);
    do_cycle(24'h600000, 1'b0, 1, 0, 2, 5);
    do_cycle(24'h100000, 1'b0, 1, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      ri = $urandom_range(0, NR - 1);
      m_wait[ri] = 4'($urandom_range(0, 15));
      apply_cfg();
      ub = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ub_list[$urandom_range(0, 12)];
      do_cycle({ub, 16'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
               ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
